// File: rtl/sfp_ctrl.sv
// Layer sequencer for the SFP accumulate/ReLU stage: walks psum tiles row by row,
// drives acc_en/write_en and the output-SRAM write aligned to the SFP output register.
module sfp_ctrl #(
    parameter int psum_aw = 11,
    parameter int out_aw  = 11,
    parameter int kw      = 8,
    parameter int ow      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [kw-1:0]      num_k,
    input  logic [ow-1:0]      num_out,
    input  logic [psum_aw-1:0] psum_base,
    input  logic [out_aw-1:0]  out_base,
    output logic               psum_cen,
    output logic [psum_aw-1:0] psum_addr,
    output logic               acc_en,
    output logic               write_en,
    output logic               out_cen,
    output logic               out_wen,
    output logic [out_aw-1:0]  out_addr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, FLUSH, WB, DONE} state_t;

    state_t state, state_nxt;

    logic [kw-1:0]      nk_q, k_cnt;
    logic [ow-1:0]      no_q, o_cnt;
    logic [psum_aw-1:0] row_base;
    logic [out_aw-1:0]  obase_q;
    logic               pipe_first;
    logic [ow-1:0]      pipe_row;
    logic               out_v;
    logic [ow-1:0]      wr_row;
    logic               accept, last_k, last_o;

    assign accept = (state == IDLE) && start;
    assign last_k = (k_cnt == nk_q - kw'(1));
    assign last_o = (o_cnt == no_q - ow'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        psum_cen  = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        write_en  = 1'b0;
        wr_row    = pipe_row - ow'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_k == '0 || num_out == '0) state_nxt = DONE;
                    else                              state_nxt = READ;
                end
            end
            READ: begin
                psum_cen = 1'b0;
                busy     = 1'b1;
                if (last_k && last_o) state_nxt = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A first-tile acc_en of row o>=1 makes the SFP emit row o-1; FLUSH emits the last row.
        if (state == FLUSH) begin
            write_en = 1'b1;
            wr_row   = no_q - ow'(1);
        end else if (acc_en && pipe_first && pipe_row != '0) begin
            write_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nk_q       <= '0;
            no_q       <= '0;
            obase_q    <= '0;
            k_cnt      <= '0;
            o_cnt      <= '0;
            row_base   <= '0;
            psum_addr  <= '0;
            acc_en     <= 1'b0;
            pipe_first <= 1'b0;
            pipe_row   <= '0;
            out_v      <= 1'b0;
            out_addr   <= '0;
        end else begin
            acc_en     <= (state == READ);
            pipe_first <= (k_cnt == '0);
            pipe_row   <= o_cnt;
            out_v      <= write_en;
            if (write_en) out_addr <= obase_q + out_aw'(wr_row);

            if (accept) begin
                nk_q      <= num_k;
                no_q      <= num_out;
                obase_q   <= out_base;
                k_cnt     <= '0;
                o_cnt     <= '0;
                row_base  <= psum_base;
                psum_addr <= psum_base;
            end else if (state == READ) begin
                // Running address: stride num_out across tiles, restart at base+o+1 per row.
                if (last_k) begin
                    k_cnt     <= '0;
                    o_cnt     <= o_cnt + ow'(1);
                    row_base  <= row_base + psum_aw'(1);
                    psum_addr <= row_base + psum_aw'(1);
                end else begin
                    k_cnt     <= k_cnt + kw'(1);
                    psum_addr <= psum_addr + psum_aw'(no_q);
                end
            end
        end
    end

    assign out_cen = ~out_v;
    assign out_wen = ~out_v;

endmodule
